// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop input synchronizer, mid-bit sampling deframer and a
// first-word-fall-through receive FIFO with sticky framing/overrun flags.
module uart_rx #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          rx_irq
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_FW       = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t             state, state_nxt;
  logic               rx_p0, rx_p1;
  logic               rxs;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         idx;
  logic [7:0]         shift;
  logic               cnt_clr, bit_smp, push, frame_evt;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               pop_ok, push_ok, overrun_evt;

  // Stage p0/p1: metastability synchronizer, idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rxs = rx_p1;

  // Deframer control
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    bit_smp   = 1'b0;
    push      = 1'b0;
    frame_evt = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_nxt = S_START;
          cnt_clr   = 1'b1;
        end
      end
      S_START: begin
        if (cnt == CNT_W'(HALF_BIT - 1)) begin
          cnt_clr   = 1'b1;
          state_nxt = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_clr = 1'b1;
          bit_smp = 1'b1;
          if (idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_clr = 1'b1;
          if (rxs) begin
            push      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            frame_evt = 1'b1;
            state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (state != S_DATA) idx <= '0;
      else if (bit_smp)    idx <= idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (bit_smp) shift[idx] <= rxs;
  end

  // Receive FIFO; a pop on an empty FIFO is ignored even when a push lands
  assign pop_ok      = rd_en && !rx_empty;
  assign push_ok     = push && (!rx_full || pop_ok);
  assign overrun_evt = push && rx_full && !pop_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_ok)
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   rx_count <= rx_count + CNT_FW'(1);
        2'b01:   rx_count <= rx_count - CNT_FW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_evt)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (overrun_evt)  overrun_err <= 1'b1;
      else if (clr_err) overrun_err <= 1'b0;
    end
  end

  assign rd_data  = mem[rd_ptr];
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CNT_FW'(FIFO_DEPTH));
  assign rx_irq   = !rx_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_empty, rx_full;
  logic [3:0] rx_count;
  logic       frame_err, overrun_err, rx_irq;

  int n_chk = 0;
  int n_pass = 0;

  uart_rx #(
    .CLK_FREQ  (10_000_000),
    .BAUD      (1_000_000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .rx_count   (rx_count),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .rx_irq     (rx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Called just after a rising edge (E0); returns just after E100.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit chk_lat,
                            input bit pop_at_push, input bit clr_at_push);
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (10) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (7) @(posedge clk);
    #1;
    rd_en   = pop_at_push;
    clr_err = clr_at_push;
    @(negedge clk);
    if (chk_lat) check("latency_97", 32'(rx_empty), 32'd1);
    @(posedge clk);
    #1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    if (chk_lat) check("latency_98", 32'(rx_empty), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    @(negedge clk);
    check("pop_data", 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_empty", 32'(rx_empty), 32'd1);
    check("rst_full", 32'(rx_full), 32'd0);
    check("rst_count", 32'(rx_count), 32'd0);
    check("rst_data", 32'(rd_data), 32'h00);
    check("rst_errs", 32'({frame_err, overrun_err, rx_irq}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single byte with latency measurement
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("a5_data", 32'(rd_data), 32'hA5);
    check("a5_irq", 32'(rx_irq), 32'd1);
    check("a5_count", 32'(rx_count), 32'd1);
    pop_expect(8'hA5);
    @(negedge clk);
    check("a5_empty", 32'(rx_empty), 32'd1);
    check("a5_irq0", 32'(rx_irq), 32'd0);
    @(posedge clk);
    #1;

    // Fill, overrun, drain across the pointer wrap
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("fill_full", 32'(rx_full), 32'd1);
    check("fill_count", 32'(rx_count), 32'd8);
    check("fill_ovr0", 32'(overrun_err), 32'd0);
    @(posedge clk);
    #1;
    send_frame(8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("ovr_flag", 32'(overrun_err), 32'd1);
    check("ovr_count", 32'(rx_count), 32'd8);
    for (int i = 0; i < 8; i++) pop_expect(8'(i));
    @(negedge clk);
    check("drain_empty", 32'(rx_empty), 32'd1);
    pulse_clr();
    @(negedge clk);
    check("ovr_clr", 32'(overrun_err), 32'd0);
    @(posedge clk);
    #1;

    // Pop on the push cycle while full, then clear on an overrun cycle
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h18, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("pp_count", 32'(rx_count), 32'd8);
    check("pp_ovr", 32'(overrun_err), 32'd0);
    check("pp_head", 32'(rd_data), 32'h11);
    @(posedge clk);
    #1;
    send_frame(8'h19, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("clr_vs_ovr", 32'(overrun_err), 32'd1);
    check("clr_vs_cnt", 32'(rx_count), 32'd8);
    for (int i = 1; i < 9; i++) pop_expect(8'(8'h10 + i));
    @(negedge clk);
    check("pp_empty", 32'(rx_empty), 32'd1);
    @(posedge clk);
    #1;

    // Framing error with a held-low line
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("fe_flag", 32'(frame_err), 32'd1);
    @(posedge clk);
    #1;
    repeat (30) @(posedge clk);
    #1;
    check("fe_nopush", 32'(rx_count), 32'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("fe_next_cnt", 32'(rx_count), 32'd1);
    check("fe_sticky", 32'(frame_err), 32'd1);
    pop_expect(8'h5A);
    pulse_clr();
    @(negedge clk);
    check("fe_clr", 32'({frame_err, overrun_err}), 32'd0);
    @(posedge clk);
    #1;

    // Glitch rejection
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("gl_empty", 32'(rx_empty), 32'd1);
    check("gl_errs", 32'({frame_err, overrun_err}), 32'd0);

    // Reset in the middle of data bit 4 with 3 bytes queued and an error set
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_frame(8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h23, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", 32'(rx_count), 32'd3);
    check("pre_rst_fe", 32'(frame_err), 32'd1);
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (10) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("mid_rst_empty", 32'(rx_empty), 32'd1);
    check("mid_rst_count", 32'(rx_count), 32'd0);
    check("mid_rst_data", 32'(rd_data), 32'h00);
    check("mid_rst_flags", 32'({frame_err, overrun_err, rx_irq, rx_full}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(rx_count), 32'd0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("c3_count", 32'(rx_count), 32'd1);
    pop_expect(8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the UART0 peripheral: oversamples the asynchronous `rx` line, deframes 8N1 characters LSB-first, and buffers received bytes in a first-word-fall-through FIFO. The UART0 register block pops the FIFO on data-register reads. The block also drives the UART0RX interrupt request (trap code 16) and sticky framing/overrun error flags.

## Interface
- `CLK_FREQ`, default 10_000_000: core clock frequency in Hz.
- `BAUD`, default 9600: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD`, using integer truncation; must be ≥ 4.
- `FIFO_DEPTH`, default 8: receive FIFO entries; must be ≥ 1 and a power of two.
- `clk`  in  1: core clock. The block uses one clock.
- `rst`  in  1: reset. Asynchronous, active-high.
- `rx`  in  1: serial line, asynchronous to `clk`; idle level is high.
- `rd_en`  in  1: pop the FIFO head. Ignored when `rx_empty` is asserted.
- `clr_err`  in  1: clear `frame_err` and `overrun_err`.
- `rd_data`  out  8: FIFO head. Valid while `rx_empty` is 0.
- `rx_empty`  out  1: FIFO holds 0 entries.
- `rx_full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `frame_err`  out  1: sticky; a stop bit was sampled low.
- `overrun_err`  out  1: sticky; a byte was dropped because the FIFO was full.
- `rx_irq`  out  1: level interrupt, equal to `!rx_empty`.

## Operation
- Input path: `rx` passes through a 2-flop synchronizer, reset to 1. All logic below uses the synchronized value `rxs`.
- FSM states and transitions:
  - IDLE: when `rxs`==0, go to START and clear the baud counter.
  - START: count `CLKS_PER_BIT/2` cycles, then re-sample. If `rxs`==1, treat it as a glitch and return to IDLE. Otherwise go to DATA with bit index 0.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rxs` into `shift[idx]`. After idx 7, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rxs`:
    - If 1: push `shift` into the FIFO and go to IDLE.
    - If 0: discard the byte, set `frame_err`, and go to WAIT_IDLE.
  - WAIT_IDLE (break or line fault): stay until `rxs`==1, then go to IDLE. No start bit is accepted while in this state.
- Baud counter: width $clog2(CLKS_PER_BIT); it reloads to 0 on every sample event.
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo `FIFO_DEPTH`. `rd_data` is driven combinationally from the entry at the read pointer.
  - Push while full with no pop in the same cycle: drop the byte and set `overrun_err`. FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both take effect. Count stays `FIFO_DEPTH`, no overrun.
  - Push and pop in the same cycle while empty: only the push takes effect (the pop is ignored). Count becomes 1.
  - Pop while empty: no effect; pointers do not move.
- Error flags:
  - `clr_err` clears both flags.
  - If `clr_err` and a new error event occur in the same cycle, set wins.
- Reset mid-frame: the FSM returns to IDLE, the FIFO empties, and the partial byte is lost. After reset deasserts, a line that is still low is treated as a start bit.

## Timing
- Reset values:
  - `rd_data` = 8'h00 (storage is cleared).
  - `rx_empty` = 1, `rx_full` = 0, `rx_count` = 0.
  - `frame_err` = 0, `overrun_err` = 0, `rx_irq` = 0.
  - FSM in IDLE, synchronizer flops = 1.
- Synchronizer latency: 2 cycles from an `rx` edge to `rxs`.
- Start-bit confirmation: `CLKS_PER_BIT/2` cycles after `rxs` falls. Each later sample is spaced exactly `CLKS_PER_BIT` cycles from the previous one.
- Push timing: the push is registered on the STOP-sample cycle. `rx_empty`, `rx_count` and `rx_irq` update on the next clock edge.
- Pop timing: `rd_en` takes effect at the clock edge. `rd_data` shows the next entry in the following cycle.
- Error flags become visible the cycle after the sample that detects the error.
- Total latency from the falling `rx` edge of the start bit to `rx_empty`==0: 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles.

## Test plan
All scenarios use `CLK_FREQ`=10_000_000 and `BAUD`=1_000_000, so `CLKS_PER_BIT`=10.
- Single byte: send 8'hA5 with a valid stop bit -> `rx_empty` falls 98 cycles after the start edge. `rd_data`=8'hA5, `rx_irq`=1, `rx_count`=1. After one `rd_en` pulse, `rx_empty`=1 and `rx_irq`=0.
- Fill and overrun: send bytes 8'h00 through 8'h08 with no reads -> after the 8th byte, `rx_full`=1 and `rx_count`=8. The 9th byte is dropped and `overrun_err`=1. Popping 8 times returns 00..07 in order, with the read pointer wrapping correctly.
- Framing error: send 8'h3C with the stop bit held low, keeping the line low for 30 cycles afterwards -> `frame_err`=1, no push, no new start detected while low. A subsequent 8'h5A is received correctly. Pulsing `clr_err` clears `frame_err`.
- Glitch rejection: pulse `rx` low for 3 cycles -> the FSM returns to IDLE, no push, no error flags set.
- Simultaneous events:
  - With the FIFO full, assert `rd_en` on the push cycle -> `rx_count` stays 8 and `overrun_err` stays 0.
  - Assert `clr_err` on the same cycle as a new overrun -> `overrun_err`=1.
- Reset mid-frame: assert `rst` during DATA bit 4 while the FIFO holds 3 bytes -> all outputs return to their reset values immediately. A new 8'hC3 is then received correctly.
